// File: rtl/cpu8_pkg.sv
// Shared definitions for the 8-bit MIPS core: datapath widths, instruction
// field positions, opcode values shared with control, and the fetch FSM states.
package cpu8_pkg;

  localparam int unsigned PC_W    = 8;
  localparam int unsigned INSTR_W = 8;
  localparam int unsigned JTGT_W  = 5;
  localparam int unsigned OPC_HI  = 7;
  localparam int unsigned OPC_LO  = 5;
  localparam int unsigned OPC_W   = OPC_HI - OPC_LO + 1;
  localparam int unsigned PAGE_W  = PC_W - JTGT_W;

  localparam logic [PC_W-1:0]    RESET_PC  = PC_W'(8'h00);
  localparam logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(8'h00);

  // Opcode values in instr[7:5]; the bubble (all zeros) decodes as R-type.
  localparam logic [OPC_W-1:0] OP_RTYPE = 3'b000;
  localparam logic [OPC_W-1:0] OP_LB    = 3'b001;
  localparam logic [OPC_W-1:0] OP_SB    = 3'b010;
  localparam logic [OPC_W-1:0] OP_ADDI  = 3'b011;
  localparam logic [OPC_W-1:0] OP_BEQ   = 3'b100;
  localparam logic [OPC_W-1:0] OP_JUMP  = 3'b101;

  typedef enum logic [1:0] {
    FS_REQ     = 2'd0,
    FS_IDLE    = 2'd1,
    FS_DISCARD = 2'd2
  } fetch_state_e;

  // Jump target: keep the current 32-instruction page, replace the offset.
  function automatic logic [PC_W-1:0] jump_target(
    input logic [PAGE_W-1:0] page,
    input logic [JTGT_W-1:0] field
  );
    return {page, field};
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry holding register for an instruction and the PC it came from.
// Catches a memory response that arrives while the IR is stalled.
// Ports:
//   clk, reset         clock and synchronous active-high reset
//   load               capture load_instr/load_pc, entry becomes full
//   unload             entry was moved to the IR, becomes empty
//   flush              discard the entry (jump redirect)
//   load_instr/load_pc data to capture
//   full               entry holds a valid instruction
//   instr/pc           held instruction and its fetch address
module fetch_skid
  import cpu8_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               unload,
  input  logic               flush,
  input  logic [INSTR_W-1:0] load_instr,
  input  logic [PC_W-1:0]    load_pc,
  output logic               full,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    pc
);

  // Flush and reset win over load; load wins over unload.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      full  <= 1'b0;
      instr <= NOP_INSTR;
      pc    <= '0;
    end else if (load) begin
      full  <= 1'b1;
      instr <= load_instr;
      pc    <= load_pc;
    end else if (unload) begin
      full  <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage of the 8-bit MIPS core. Holds the PC, fetches over a req/valid
// instruction-memory interface, presents a registered instruction to control,
// and redirects on a jump using a one-entry skid plus response discard.
// Ports:
//   clk, reset              clock and synchronous active-high reset
//   imem_req, imem_addr     fetch request and its address (held until valid)
//   imem_valid, imem_rdata  memory response completing the request
//   stall                   downstream cannot consume the instruction
//   jump                    control's jump decision for the current instr
//   instr, opcode           registered instruction (00 when empty) and [7:5]
//   instr_valid, pc_out     IR holds a real instruction / its fetch address
module instr_fetch
  import cpu8_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               jump,
  output logic [INSTR_W-1:0] instr,
  output logic [OPC_W-1:0]   opcode,
  output logic               instr_valid,
  output logic [PC_W-1:0]    pc_out
);

  fetch_state_e       state;
  fetch_state_e       state_d;
  logic [PC_W-1:0]    fetch_pc;
  logic [PC_W-1:0]    fetch_pc_d;
  logic [PC_W-1:0]    addr_d;
  logic [PC_W-1:0]    pc_out_d;
  logic [PC_W-1:0]    target;
  logic [INSTR_W-1:0] instr_d;
  logic               instr_valid_d;

  logic               consume;
  logic               ir_free;
  logic               jt;

  logic               skid_load;
  logic               skid_unload;
  logic               skid_flush;
  logic               skid_full;
  logic [INSTR_W-1:0] skid_instr;
  logic [PC_W-1:0]    skid_pc;

  assign consume  = instr_valid && !stall;
  assign ir_free  = !instr_valid || !stall;
  // Jump only counts on a real instruction that is actually consumed.
  assign jt       = consume && jump;
  assign target   = jump_target(pc_out[PC_W-1:JTGT_W], instr[JTGT_W-1:0]);
  assign opcode   = instr[OPC_HI:OPC_LO];
  // No request while reset is asserted; IDLE waits for the skid to drain.
  assign imem_req = !reset && (state != FS_IDLE);

  fetch_skid u_skid (
    .clk        (clk),
    .reset      (reset),
    .load       (skid_load),
    .unload     (skid_unload),
    .flush      (skid_flush),
    .load_instr (imem_rdata),
    .load_pc    (fetch_pc),
    .full       (skid_full),
    .instr      (skid_instr),
    .pc         (skid_pc)
  );

  // Next-state and datapath control.
  always_comb begin
    state_d       = state;
    fetch_pc_d    = fetch_pc;
    instr_d       = instr;
    instr_valid_d = instr_valid;
    pc_out_d      = pc_out;
    skid_load     = 1'b0;
    skid_unload   = 1'b0;
    skid_flush    = 1'b0;

    // A consumed IR empties (this also flushes on a jump) unless refilled below.
    if (consume) begin
      instr_d       = NOP_INSTR;
      instr_valid_d = 1'b0;
    end

    case (state)
      FS_REQ: begin
        if (jt) begin
          fetch_pc_d = target;
          // Without the response yet, its data must still be swallowed.
          state_d    = imem_valid ? FS_REQ : FS_DISCARD;
        end else if (imem_valid) begin
          fetch_pc_d = fetch_pc + PC_W'(1);
          if (ir_free) begin
            instr_d       = imem_rdata;
            instr_valid_d = 1'b1;
            pc_out_d      = fetch_pc;
          end else begin
            skid_load = 1'b1;
            state_d   = FS_IDLE;
          end
        end
      end

      FS_IDLE: begin
        if (jt) begin
          fetch_pc_d = target;
          skid_flush = 1'b1;
          state_d    = FS_REQ;
        end else if (ir_free && skid_full) begin
          instr_d       = skid_instr;
          instr_valid_d = 1'b1;
          pc_out_d      = skid_pc;
          skid_unload   = 1'b1;
          state_d       = FS_REQ;
        end else if (!skid_full) begin
          state_d = FS_REQ;
        end
      end

      FS_DISCARD: begin
        if (imem_valid) begin
          state_d = FS_REQ;
        end
      end

      default: begin
        state_d = FS_REQ;
      end
    endcase
  end

  // The address stays on the abandoned request until its response is dropped.
  assign addr_d = (state_d == FS_DISCARD) ? imem_addr : fetch_pc_d;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FS_REQ;
      fetch_pc    <= RESET_PC;
      imem_addr   <= RESET_PC;
      instr       <= NOP_INSTR;
      instr_valid <= 1'b0;
      pc_out      <= '0;
    end else begin
      state       <= state_d;
      fetch_pc    <= fetch_pc_d;
      imem_addr   <= addr_d;
      instr       <= instr_d;
      instr_valid <= instr_valid_d;
      pc_out      <= pc_out_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a vector table for the reset, stream
// and stall/skid behaviour, hand sequences for jump corner cases and reset,
// then random stall/jump/latency against an in-order program-flow model.
`timescale 1ns/1ps
module tb_instr_fetch;
  import cpu8_pkg::*;

  logic       clk;
  logic       reset;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_valid;
  logic [7:0] imem_rdata;
  logic       stall;
  logic       jump;
  logic [7:0] instr;
  logic [2:0] opcode;
  logic       instr_valid;
  logic [7:0] pc_out;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  instr_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_valid  (imem_valid),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .jump        (jump),
    .instr       (instr),
    .opcode      (opcode),
    .instr_valid (instr_valid),
    .pc_out      (pc_out)
  );

  int         errors;
  int         checks;
  logic [7:0] mem [256];
  int         lat_fixed;
  int         lat_max;
  bit         force_valid;
  bit         pending;
  int         lat_left;
  bit         hold_prev;
  logic [7:0] addr_prev;
  logic [7:0] exp_pc;
  int         consumed;

  typedef struct {
    logic       s;
    logic       j;
    logic       req;
    logic [7:0] addr;
    logic       v;
    logic [7:0] pc;
    logic [7:0] ins;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, got, exp);
    end
  endtask

  // One clock cycle: drive inputs at the negedge, answer memory, check the
  // program-flow model, then sample outputs at the next negedge.
  task automatic step(input logic r, input logic s, input logic j);
    logic       cons;
    logic       bubble;
    logic [7:0] word;
    reset = r;
    stall = s;
    jump  = j;
    #1;
    if (hold_prev && !r) begin
      chk("req_held", 32'(imem_req), 32'd1);
      chk("addr_held", 32'(imem_addr), 32'(addr_prev));
    end
    if (r) chk("req_in_reset", 32'(imem_req), 32'd0);

    if (force_valid) begin
      imem_valid = 1'b1;
      imem_rdata = 8'hFF;
      pending    = 1'b0;
    end else if (imem_req) begin
      if (!pending) begin
        pending  = 1'b1;
        lat_left = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(lat_max, 0));
      end
      if (lat_left == 0) begin
        imem_valid = 1'b1;
        imem_rdata = mem[imem_addr];
        pending    = 1'b0;
      end else begin
        imem_valid = 1'b0;
        imem_rdata = 8'($urandom);
        lat_left--;
      end
    end else begin
      imem_valid = 1'b0;
      imem_rdata = 8'($urandom);
      pending    = 1'b0;
    end
    hold_prev = imem_req && !imem_valid && !r;
    addr_prev = imem_addr;

    cons   = !r && (instr_valid === 1'b1) && !s;
    bubble = 1'b0;
    if (cons) begin
      chk("flow_pc", 32'(pc_out), 32'(exp_pc));
      chk("flow_instr", 32'(instr), 32'(mem[exp_pc]));
      consumed++;
      word = mem[exp_pc];
      if (j) begin
        exp_pc = {exp_pc[7:5], word[4:0]};
        bubble = 1'b1;
      end else begin
        exp_pc = exp_pc + 8'd1;
      end
    end
    if (r) exp_pc = 8'h00;

    @(posedge clk);
    @(negedge clk);
    if (bubble) chk("bubble_after_jump", 32'(instr_valid), 32'd0);
    chk("opcode_field", 32'(opcode), 32'(instr[7:5]));
    if (!instr_valid) chk("empty_is_nop", 32'(instr), 32'd0);
  endtask

  task automatic run_until(input logic [7:0] pc, input int budget, input string name);
    bit hit;
    hit = 1'b0;
    for (int n = 0; n < budget && !hit; n++) begin
      step(1'b0, 1'b0, 1'b0);
      hit = (instr_valid === 1'b1) && (pc_out == pc);
    end
    chk(name, 32'(hit), 32'd1);
  endtask

  initial begin
    int start_consumed;
    errors      = 0;
    checks      = 0;
    reset       = 1'b1;
    stall       = 1'b0;
    jump        = 1'b0;
    imem_valid  = 1'b0;
    imem_rdata  = 8'h00;
    lat_fixed   = 0;
    lat_max     = 3;
    force_valid = 1'b0;
    pending     = 1'b0;
    lat_left    = 0;
    hold_prev   = 1'b0;
    addr_prev   = 8'h00;
    exp_pc      = 8'h00;
    consumed    = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA0;
    mem[8'h23] = 8'hB4;

    //           s     j     req   addr   v     pc     instr
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 8'h01, 1'b1, 8'h00, 8'hA0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 8'h02, 1'b1, 8'h01, 8'hA1};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 8'h03, 1'b1, 8'h02, 8'hA2};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 8'h04, 1'b1, 8'h03, 8'hA3};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 8'h05, 1'b1, 8'h04, 8'hA4};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 8'h06, 1'b1, 8'h05, 8'hA5};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 8'h07, 1'b1, 8'h05, 8'hA5};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 8'h07, 1'b1, 8'h05, 8'hA5};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 8'h07, 1'b1, 8'h05, 8'hA5};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 8'h07, 1'b1, 8'h06, 8'hA6};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 8'h08, 1'b1, 8'h07, 8'hA7};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 8'h09, 1'b1, 8'h08, 8'hA8};

    @(negedge clk);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", 32'(instr), 32'd0);
    chk("rst_opcode", 32'(opcode), 32'd0);
    chk("rst_pc_out", 32'(pc_out), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'h00);

    // Zero-wait stream, then a three-cycle stall with the skid catching 06.
    for (int k = 0; k < 12; k++) begin
      step(1'b0, vecs[k].s, vecs[k].j);
      chk($sformatf("vec%0d_req", k), 32'(imem_req), 32'(vecs[k].req));
      chk($sformatf("vec%0d_addr", k), 32'(imem_addr), 32'(vecs[k].addr));
      chk($sformatf("vec%0d_valid", k), 32'(instr_valid), 32'(vecs[k].v));
      chk($sformatf("vec%0d_pc", k), 32'(pc_out), 32'(vecs[k].pc));
      chk($sformatf("vec%0d_instr", k), 32'(instr), 32'(vecs[k].ins));
    end

    // Zero-wait jump from 23 (B4) to 34.
    run_until(8'h22, 64, "reach_22");
    step(1'b0, 1'b0, 1'b0);
    chk("j0_pc", 32'(pc_out), 32'h23);
    chk("j0_instr", 32'(instr), 32'hB4);
    chk("j0_opcode", 32'(opcode), 32'h5);
    step(1'b0, 1'b0, 1'b1);
    chk("j0_bubble", 32'(instr_valid), 32'd0);
    chk("j0_bubble_opc", 32'(opcode), 32'd0);
    chk("j0_target_addr", 32'(imem_addr), 32'h34);
    chk("j0_target_req", 32'(imem_req), 32'd1);
    step(1'b0, 1'b0, 1'b0);
    chk("j0_land_valid", 32'(instr_valid), 32'd1);
    chk("j0_land_pc", 32'(pc_out), 32'h34);
    chk("j0_land_instr", 32'(instr), 32'h94);

    // PC wrap FF -> 00.
    run_until(8'hFF, 300, "reach_ff");
    step(1'b0, 1'b0, 1'b0);
    chk("wrap_pc", 32'(pc_out), 32'h00);
    chk("wrap_valid", 32'(instr_valid), 32'd1);

    // Jump while the request for 11 is outstanding (latency 3); target 07.
    mem[8'h10] = 8'h47;
    run_until(8'h10, 32, "reach_10");
    lat_fixed = 3;
    step(1'b0, 1'b1, 1'b0);
    chk("jo_pending_addr", 32'(imem_addr), 32'h11);
    step(1'b0, 1'b0, 1'b1);
    chk("jo_flushed", 32'(instr_valid), 32'd0);
    chk("jo_addr_kept", 32'(imem_addr), 32'h11);
    step(1'b0, 1'b0, 1'b0);
    chk("jo_discard_addr", 32'(imem_addr), 32'h11);
    chk("jo_discard_valid", 32'(instr_valid), 32'd0);
    step(1'b0, 1'b0, 1'b0);
    chk("jo_dropped", 32'(instr_valid), 32'd0);
    chk("jo_target_addr", 32'(imem_addr), 32'h07);
    chk("jo_target_req", 32'(imem_req), 32'd1);
    run_until(8'h07, 8, "jo_land_07");

    // Reset while discarding, with a late response during reset.
    run_until(8'h09, 16, "reach_09");
    step(1'b0, 1'b0, 1'b1);
    chk("rm_discard_addr", 32'(imem_addr), 32'h0A);
    force_valid = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    chk("rm_req", 32'(imem_req), 32'd0);
    chk("rm_valid", 32'(instr_valid), 32'd0);
    chk("rm_opcode", 32'(opcode), 32'd0);
    chk("rm_addr", 32'(imem_addr), 32'h00);
    step(1'b1, 1'b0, 1'b0);
    chk("rm_valid2", 32'(instr_valid), 32'd0);
    force_valid = 1'b0;
    lat_fixed   = 0;
    step(1'b0, 1'b0, 1'b0);
    chk("rm_restart_pc", 32'(pc_out), 32'h00);
    chk("rm_restart_valid", 32'(instr_valid), 32'd1);
    chk("rm_restart_instr", 32'(instr), 32'hA0);

    // Jump held during stall with the skid full; redirect only when unstalled.
    mem[8'h05] = 8'h3C;
    run_until(8'h05, 16, "reach_05");
    step(1'b0, 1'b1, 1'b1);
    chk("js_idle_req", 32'(imem_req), 32'd0);
    chk("js_held_pc", 32'(pc_out), 32'h05);
    step(1'b0, 1'b1, 1'b1);
    chk("js_held_pc2", 32'(pc_out), 32'h05);
    chk("js_held_valid", 32'(instr_valid), 32'd1);
    step(1'b0, 1'b0, 1'b1);
    chk("js_flushed", 32'(instr_valid), 32'd0);
    chk("js_target_addr", 32'(imem_addr), 32'h1C);
    step(1'b0, 1'b0, 1'b0);
    chk("js_land_pc", 32'(pc_out), 32'h1C);
    chk("js_land_instr", 32'(instr), 32'hBC);
    step(1'b0, 1'b0, 1'b0);
    chk("js_next_pc", 32'(pc_out), 32'h1D);

    // Random program, stalls, jumps and memory latency.
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    lat_fixed      = -1;
    start_consumed = consumed;
    for (int n = 0; n < 3000; n++) begin
      step(1'b0, $urandom_range(99, 0) < 30, $urandom_range(99, 0) < 25);
    end
    chk("random_progress", 32'(consumed - start_consumed > 200), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
